// File: rtl/execute_stage_if.sv
// ----------------------------------------------------------------------------
// execute_stage_if
// Bundles the decode-side handshake and operands, the downstream result
// handshake and the fetch redirect into one connection point.
//
//   master : the environment around the execute stage (decode drives the
//            dec_* fields, the consumer drives ex_ready, fetch observes the
//            redirect).
//   slave  : the execute stage itself.
//
// Signals
//   dec_valid/dec_ready          decode handshake
//   dec_pc, dec_rs1_val,
//   dec_rs2_val, dec_imm         32-bit operands
//   dec_rs1, dec_rs2, dec_rd     register indices
//   dec_alu_sel, dec_alu_mod     ALU operation select / modifier
//   dec_a_pc, dec_b_imm          operand muxing (A=pc, B=imm)
//   dec_branch, dec_jump,
//   dec_br_cond                  control-flow class and branch funct3
//   ex_valid/ex_ready            result handshake
//   ex_result, ex_rd,
//   ex_store_data                result payload
//   redirect_valid, redirect_pc  one-cycle fetch redirect
// ----------------------------------------------------------------------------
interface execute_stage_if;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_rs1_val;
    logic [31:0] dec_rs2_val;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [2:0]  dec_alu_sel;
    logic        dec_alu_mod;
    logic        dec_a_pc;
    logic        dec_b_imm;
    logic        dec_branch;
    logic        dec_jump;
    logic [2:0]  dec_br_cond;

    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic [31:0] ex_store_data;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output dec_valid, dec_pc, dec_rs1_val, dec_rs2_val, dec_imm,
               dec_rs1, dec_rs2, dec_rd, dec_alu_sel, dec_alu_mod,
               dec_a_pc, dec_b_imm, dec_branch, dec_jump, dec_br_cond,
               ex_ready,
        input  dec_ready, ex_valid, ex_result, ex_rd, ex_store_data,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  dec_valid, dec_pc, dec_rs1_val, dec_rs2_val, dec_imm,
               dec_rs1, dec_rs2, dec_rd, dec_alu_sel, dec_alu_mod,
               dec_a_pc, dec_b_imm, dec_branch, dec_jump, dec_br_cond,
               ex_ready,
        output dec_ready, ex_valid, ex_result, ex_rd, ex_store_data,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
// Two-slot execute stage of a 32-bit RISC-V style pipeline. An operand
// register (OP) feeds an external combinational ALU and a private branch
// comparator; the result is captured in an output register (OUT) that is
// handed downstream with a valid/ready handshake. Jumps and taken branches
// raise a one-cycle redirect as the instruction leaves OP.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   bus            execute_stage_if.slave (decode handshake, result
//                  handshake, redirect)
//   alu_a, alu_b   ALU operands driven from OP
//   alu_sel,
//   alu_mod        ALU operation driven from OP
//   alu_result     combinational ALU result
//   wb_valid,
//   wb_rd,
//   wb_value       writeback bypass (only with EXEC_FORWARD_EN)
//
// Configuration
//   EXEC_FORWARD_EN  when defined, rs1/rs2 are bypassed from OUT first and
//                    then from the writeback port. When undefined the
//                    operand values are used exactly as captured and the
//                    wb_* ports do not exist.
// ----------------------------------------------------------------------------
module execute_stage (
    input  logic                  clk,
    input  logic                  rst_n,
    execute_stage_if.slave        bus,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [2:0]            alu_sel,
    output logic                  alu_mod,
    input  logic [31:0]           alu_result
`ifdef EXEC_FORWARD_EN
    ,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_rd,
    input  logic [31:0]           wb_value
`endif
);

    // Branch funct3 encodings
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_cond_e;

    // Operand register
    logic        op_valid;
    logic [31:0] op_pc;
    logic [31:0] op_rs1_val;
    logic [31:0] op_rs2_val;
    logic [31:0] op_imm;
    logic [4:0]  op_rd;
    logic [2:0]  op_alu_sel;
    logic        op_alu_mod;
    logic        op_a_pc;
    logic        op_b_imm;
    logic        op_branch;
    logic        op_jump;
    logic [2:0]  op_br_cond;

    // Output register
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [31:0] out_store;

    logic        op_adv;
    logic        accept;
    logic        br_taken;
    logic        redirect;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic [31:0] pc_plus_imm;
    logic [31:0] pc_plus_4;

    // OP may leave whenever OUT is empty or being drained this cycle
    assign op_adv        = op_valid && (!out_valid || bus.ex_ready);
    assign bus.dec_ready = !op_valid || op_adv;
    assign accept        = bus.dec_valid && bus.dec_ready;

`ifdef EXEC_FORWARD_EN
    logic [4:0] op_rs1;
    logic [4:0] op_rs2;

    // OUT holds the next-older instruction, so it has priority over writeback
    always_comb begin
        fwd_rs1 = op_rs1_val;
        fwd_rs2 = op_rs2_val;
        if (out_valid && (out_rd != 5'd0) && (out_rd == op_rs1)) begin
            fwd_rs1 = out_result;
        end else if (wb_valid && (wb_rd != 5'd0) && (wb_rd == op_rs1)) begin
            fwd_rs1 = wb_value;
        end
        if (out_valid && (out_rd != 5'd0) && (out_rd == op_rs2)) begin
            fwd_rs2 = out_result;
        end else if (wb_valid && (wb_rd != 5'd0) && (wb_rd == op_rs2)) begin
            fwd_rs2 = wb_value;
        end
    end
`else
    // Source indices are only needed for bypassing
    logic unused_rs_idx;
    assign unused_rs_idx = ^{bus.dec_rs1, bus.dec_rs2};

    always_comb begin
        fwd_rs1 = op_rs1_val;
        fwd_rs2 = op_rs2_val;
    end
`endif

    // ALU operand selection
    assign alu_a   = op_a_pc  ? op_pc  : fwd_rs1;
    assign alu_b   = op_b_imm ? op_imm : fwd_rs2;
    assign alu_sel = op_alu_sel;
    assign alu_mod = op_alu_mod;

    // Dedicated comparator so branch resolution does not depend on the ALU op
    always_comb begin
        br_taken = 1'b0;
        case (op_br_cond)
            BR_EQ:   br_taken = (fwd_rs1 == fwd_rs2);
            BR_NE:   br_taken = (fwd_rs1 != fwd_rs2);
            BR_LT:   br_taken = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            BR_GE:   br_taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            BR_LTU:  br_taken = (fwd_rs1 <  fwd_rs2);
            BR_GEU:  br_taken = (fwd_rs1 >= fwd_rs2);
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus_imm = op_pc + op_imm;
    assign pc_plus_4   = op_pc + 32'd4;

    // Redirect only as the instruction leaves OP, so a stall cannot repeat it
    assign redirect           = op_adv && (op_jump || (op_branch && br_taken));
    assign bus.redirect_valid = redirect;
    assign bus.redirect_pc    = (op_jump && !op_a_pc) ? {alu_result[31:1], 1'b0}
                                                      : pc_plus_imm;

    // Operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid   <= 1'b0;
            op_pc      <= '0;
            op_rs1_val <= '0;
            op_rs2_val <= '0;
            op_imm     <= '0;
            op_rd      <= '0;
            op_alu_sel <= '0;
            op_alu_mod <= 1'b0;
            op_a_pc    <= 1'b0;
            op_b_imm   <= 1'b0;
            op_branch  <= 1'b0;
            op_jump    <= 1'b0;
            op_br_cond <= '0;
        end else begin
            // An instruction accepted while a redirect fires is on the wrong path
            op_valid <= (accept && !redirect) || (op_valid && !op_adv);
            if (accept) begin
                op_pc      <= bus.dec_pc;
                op_rs1_val <= bus.dec_rs1_val;
                op_rs2_val <= bus.dec_rs2_val;
                op_imm     <= bus.dec_imm;
                op_rd      <= bus.dec_rd;
                op_alu_sel <= bus.dec_alu_sel;
                op_alu_mod <= bus.dec_alu_mod;
                op_a_pc    <= bus.dec_a_pc;
                op_b_imm   <= bus.dec_b_imm;
                op_branch  <= bus.dec_branch;
                op_jump    <= bus.dec_jump;
                op_br_cond <= bus.dec_br_cond;
            end
        end
    end

`ifdef EXEC_FORWARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rs1 <= '0;
            op_rs2 <= '0;
        end else if (accept) begin
            op_rs1 <= bus.dec_rs1;
            op_rs2 <= bus.dec_rs2;
        end
    end
`endif

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_store  <= '0;
        end else if (op_adv) begin
            out_valid  <= 1'b1;
            out_result <= op_jump ? pc_plus_4 : alu_result;
            out_rd     <= op_branch ? 5'd0 : op_rd;
            out_store  <= fwd_rs2;
        end else if (bus.ex_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign bus.ex_valid      = out_valid;
    assign bus.ex_result     = out_result;
    assign bus.ex_rd         = out_rd;
    assign bus.ex_store_data = out_store;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    execute_stage_if bus();

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic        alu_mod;
    logic [31:0] alu_result;
`ifdef EXEC_FORWARD_EN
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
`endif

    execute_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_mod    (alu_mod),
        .alu_result (alu_result)
`ifdef EXEC_FORWARD_EN
        ,
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_value   (wb_value)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic        mod;
        logic        a_pc;
        logic        b_imm;
        logic        branch;
        logic        jump;
        logic [2:0]  cond;
    } instr_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic [31:0] store;
    } res_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU (RV32 funct3 ordering, mod selects SUB/SRA)
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] sel, input logic mod);
        logic [31:0] r;
        case (sel)
            3'd0: r = mod ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (mod) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_sel, alu_mod);

    function automatic logic br_fn(input logic [2:0] cond, input logic [31:0] a, input logic [31:0] b);
        case (cond)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: an instruction sits in "waiting to execute" until
    // the result slot is free or draining, then its result is computed and
    // it joins the result queue; results leave when ex_ready is high.
    // ------------------------------------------------------------------
    instr_t op_q[$];
    res_t   out_q[$];
    instr_t m_op;
    instr_t m_new;
    res_t   m_res;
    logic   m_op_occ, m_out_occ, m_adv, m_ready, m_take;
    logic [31:0] m_f1, m_f2, m_a, m_b, m_alu, m_rpc;

    always @(negedge clk) begin
        if (!rst_n) begin
            op_q.delete();
            out_q.delete();
            check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
            check("rst_redirect", 32'(bus.redirect_valid), 32'd0);
        end else begin
            m_op_occ  = (op_q.size() != 0);
            m_out_occ = (out_q.size() != 0);
            m_adv     = m_op_occ && (!m_out_occ || bus.ex_ready);
            m_ready   = !m_op_occ || m_adv;
            m_take    = 1'b0;
            m_rpc     = '0;
            m_res     = '0;

            check("dec_ready", 32'(bus.dec_ready), 32'(m_ready));
            check("ex_valid", 32'(bus.ex_valid), 32'(m_out_occ));
            if (m_out_occ) begin
                check("ex_result", bus.ex_result, out_q[0].result);
                check("ex_rd", 32'(bus.ex_rd), 32'(out_q[0].rd));
                check("ex_store_data", bus.ex_store_data, out_q[0].store);
            end

            if (m_op_occ) begin
                m_op = op_q[0];
                m_f1 = m_op.rs1_val;
                m_f2 = m_op.rs2_val;
`ifdef EXEC_FORWARD_EN
                if (m_out_occ && out_q[0].rd != 0 && out_q[0].rd == m_op.rs1) m_f1 = out_q[0].result;
                else if (wb_valid && wb_rd != 0 && wb_rd == m_op.rs1) m_f1 = wb_value;
                if (m_out_occ && out_q[0].rd != 0 && out_q[0].rd == m_op.rs2) m_f2 = out_q[0].result;
                else if (wb_valid && wb_rd != 0 && wb_rd == m_op.rs2) m_f2 = wb_value;
`endif
                m_a   = m_op.a_pc  ? m_op.pc  : m_f1;
                m_b   = m_op.b_imm ? m_op.imm : m_f2;
                m_alu = alu_fn(m_a, m_b, m_op.sel, m_op.mod);
                m_take = m_op.jump || (m_op.branch && br_fn(m_op.cond, m_f1, m_f2));
                m_rpc  = (m_op.jump && !m_op.a_pc) ? (m_alu & ~32'd1) : m_op.pc + m_op.imm;
                m_res.result = m_op.jump ? m_op.pc + 32'd4 : m_alu;
                m_res.rd     = m_op.branch ? 5'd0 : m_op.rd;
                m_res.store  = m_f2;
                check("alu_a", alu_a, m_a);
                check("alu_b", alu_b, m_b);
                check("alu_op", {28'd0, alu_sel, alu_mod}, {28'd0, m_op.sel, m_op.mod});
            end

            check("redirect_valid", 32'(bus.redirect_valid), 32'(m_adv && m_take));
            if (m_adv && m_take) check("redirect_pc", bus.redirect_pc, m_rpc);

            // Advance the model across the coming rising edge
            if (m_out_occ && bus.ex_ready) void'(out_q.pop_front());
            if (m_adv) begin
                void'(op_q.pop_front());
                out_q.push_back(m_res);
            end
            if (bus.dec_valid && m_ready && !(m_adv && m_take)) begin
                m_new.pc      = bus.dec_pc;
                m_new.rs1_val = bus.dec_rs1_val;
                m_new.rs2_val = bus.dec_rs2_val;
                m_new.imm     = bus.dec_imm;
                m_new.rs1     = bus.dec_rs1;
                m_new.rs2     = bus.dec_rs2;
                m_new.rd      = bus.dec_rd;
                m_new.sel     = bus.dec_alu_sel;
                m_new.mod     = bus.dec_alu_mod;
                m_new.a_pc    = bus.dec_a_pc;
                m_new.b_imm   = bus.dec_b_imm;
                m_new.branch  = bus.dec_branch;
                m_new.jump    = bus.dec_jump;
                m_new.cond    = bus.dec_br_cond;
                op_q.push_back(m_new);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input instr_t i);
        bus.dec_valid   = 1'b1;
        bus.dec_pc      = i.pc;
        bus.dec_rs1_val = i.rs1_val;
        bus.dec_rs2_val = i.rs2_val;
        bus.dec_imm     = i.imm;
        bus.dec_rs1     = i.rs1;
        bus.dec_rs2     = i.rs2;
        bus.dec_rd      = i.rd;
        bus.dec_alu_sel = i.sel;
        bus.dec_alu_mod = i.mod;
        bus.dec_a_pc    = i.a_pc;
        bus.dec_b_imm   = i.b_imm;
        bus.dec_branch  = i.branch;
        bus.dec_jump    = i.jump;
        bus.dec_br_cond = i.cond;
    endtask

    task automatic idle();
        bus.dec_valid = 1'b0;
    endtask

    function automatic instr_t alu_op(input logic [2:0] sel, input logic mod,
                                      input logic [4:0] rs1, input logic [31:0] v1,
                                      input logic [4:0] rs2, input logic [31:0] v2,
                                      input logic [4:0] rd);
        instr_t i;
        i = '0;
        i.sel = sel; i.mod = mod;
        i.rs1 = rs1; i.rs1_val = v1;
        i.rs2 = rs2; i.rs2_val = v2;
        i.rd  = rd;  i.pc = 32'h1000;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        logic [2:0] conds [6];
        int unsigned kind;
        conds = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        i = '0;
        i.pc      = $urandom & 32'hFFFF_FFFC;
        i.rs1     = 5'($urandom_range(0, 31));
        i.rs2     = 5'($urandom_range(0, 31));
        i.rd      = 5'($urandom_range(0, 31));
        i.rs1_val = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 31)) : $urandom;
        i.rs2_val = ($urandom_range(0, 3) == 0) ? i.rs1_val : $urandom;
        i.imm     = $urandom;
        kind = $urandom_range(0, 5);
        if (kind <= 2) begin
            i.sel   = 3'($urandom_range(0, 7));
            i.mod   = 1'($urandom_range(0, 1));
            i.b_imm = 1'($urandom_range(0, 1));
        end else if (kind <= 4) begin
            i.branch = 1'b1;
            i.cond   = conds[$urandom_range(0, 5)];
            i.mod    = 1'b1;
        end else begin
            i.jump  = 1'b1;
            i.a_pc  = 1'($urandom_range(0, 1));
            i.b_imm = 1'b1;
        end
        return i;
    endfunction

    // ------------------------------------------------------------------
    // Directed tests with hand-computed expectations, then random traffic
    // ------------------------------------------------------------------
    instr_t t;
    logic [31:0] got[$];
    int hits;
    logic taken3;

    initial begin
        rst_n        = 1'b0;
        bus.ex_ready = 1'b1;
        drive('0);
        idle();
`ifdef EXEC_FORWARD_EN
        wb_valid = 1'b0; wb_rd = '0; wb_value = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dec_ready", 32'(bus.dec_ready), 32'd1);
        check("reset_ex_result", bus.ex_result, 32'd0);
        check("reset_ex_rd", 32'(bus.ex_rd), 32'd0);
        step();
        rst_n = 1'b1;

        // ADD x1=5 + x2=7 -> 12, valid two cycles after accept
        step();
        drive(alu_op(3'd0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd1));
        @(negedge clk);
        check("add_accept_ready", 32'(bus.dec_ready), 32'd1);
        step();
        idle();
        @(negedge clk);
        check("add_lat1_valid", 32'(bus.ex_valid), 32'd0);
        step();
        @(negedge clk);
        check("add_lat2_valid", 32'(bus.ex_valid), 32'd1);
        check("add_result", bus.ex_result, 32'd12);
        check("add_rd", 32'(bus.ex_rd), 32'd1);
        step();

        // Three instructions against a 3-cycle stall
        bus.ex_ready = 1'b0;
        drive(alu_op(3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd1, 5'd1));
        step();
        drive(alu_op(3'd4, 1'b0, 5'd3, 32'hF0, 5'd4, 32'hFF, 5'd2));
        step();
        drive(alu_op(3'd0, 1'b1, 5'd5, 32'd10, 5'd6, 32'd3, 5'd3));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_dec_ready", 32'(bus.dec_ready), 32'd0);
            check("stall_hold_result", bus.ex_result, 32'd2);
            step();
        end
        bus.ex_ready = 1'b1;
        got.delete();
        taken3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.ex_valid && bus.ex_ready) got.push_back(bus.ex_result);
            if (bus.dec_valid && bus.dec_ready) taken3 = 1'b1;
            step();
            if (taken3) idle();
        end
        check("stall_count", 32'(got.size()), 32'd3);
        if (got.size() > 0) check("stall_order0", got[0], 32'd2);
        if (got.size() > 1) check("stall_order1", got[1], 32'h0F);
        if (got.size() > 2) check("stall_order2", got[2], 32'd7);

        // BEQ taken, younger instruction accepted in the redirect cycle is dropped
        t = alu_op(3'd0, 1'b1, 5'd8, 32'd9, 5'd9, 32'd9, 5'd7);
        t.branch = 1'b1; t.cond = 3'd0; t.pc = 32'h100; t.imm = 32'h20;
        drive(t);
        step();
        drive(alu_op(3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd1, 5'd5));
        @(negedge clk);
        check("beq_redirect", 32'(bus.redirect_valid), 32'd1);
        check("beq_redirect_pc", bus.redirect_pc, 32'h120);
        check("beq_victim_ready", 32'(bus.dec_ready), 32'd1);
        step();
        idle();
        @(negedge clk);
        check("beq_redirect_once", 32'(bus.redirect_valid), 32'd0);
        check("beq_rd_zero", 32'(bus.ex_rd), 32'd0);
        hits = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.ex_valid && bus.ex_rd == 5'd5) hits++;
            step();
            @(negedge clk);
        end
        check("beq_victim_dropped", 32'(hits), 32'd0);
        step();

        // JALR rs1=0x203, imm=4, pc=0x40
        t = alu_op(3'd0, 1'b0, 5'd6, 32'h203, 5'd0, 32'd0, 5'd1);
        t.jump = 1'b1; t.b_imm = 1'b1; t.imm = 32'd4; t.pc = 32'h40;
        drive(t);
        step();
        idle();
        @(negedge clk);
        check("jalr_redirect", 32'(bus.redirect_valid), 32'd1);
        check("jalr_redirect_pc", bus.redirect_pc, 32'h206);
        step();
        @(negedge clk);
        check("jalr_result", bus.ex_result, 32'h44);
        check("jalr_rd", 32'(bus.ex_rd), 32'd1);
        step();

`ifdef EXEC_FORWARD_EN
        drive(alu_op(3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3));
        step();
        drive(alu_op(3'd0, 1'b0, 5'd3, 32'h55, 5'd3, 32'h55, 5'd4));
        step();
        idle();
        step();
        @(negedge clk);
        check("fwd_out_result", bus.ex_result, 32'd6);
        step();
        drive(alu_op(3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd0));
        step();
        drive(alu_op(3'd0, 1'b0, 5'd0, 32'd10, 5'd0, 32'd20, 5'd6));
        step();
        idle();
        step();
        @(negedge clk);
        check("fwd_x0_result", bus.ex_result, 32'd30);
        step();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_value = 32'd100;
        drive(alu_op(3'd0, 1'b0, 5'd9, 32'd0, 5'd10, 32'd1, 5'd11));
        step();
        idle();
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        check("fwd_wb_result", bus.ex_result, 32'd101);
        step();
`endif

        // Reset while OUT is valid and stalled
        bus.ex_ready = 1'b0;
        drive(alu_op(3'd6, 1'b0, 5'd1, 32'h10, 5'd2, 32'h01, 5'd12));
        step();
        drive(alu_op(3'd7, 1'b0, 5'd1, 32'hFF, 5'd2, 32'h0F, 5'd13));
        step();
        idle();
        @(negedge clk);
        check("rst_pre_valid", 32'(bus.ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_async_ready", 32'(bus.dec_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        bus.ex_ready = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(bus.dec_ready), 32'd1);
        hits = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.ex_valid) hits++;
            step();
            @(negedge clk);
        end
        check("rst_nothing_emerges", 32'(hits), 32'd0);
        step();

        // Randomized traffic checked by the model
        for (int unsigned c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 7) drive(rand_instr());
            else idle();
            bus.ex_ready = ($urandom_range(0, 9) < 7);
`ifdef EXEC_FORWARD_EN
            wb_valid = 1'($urandom_range(0, 1));
            wb_rd    = 5'($urandom_range(0, 31));
            wb_value = $urandom;
`endif
            step();
        end
        idle();
        bus.ex_ready = 1'b1;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
